// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared widths, limits, FSM state type and BCD helpers for the alarm clock
package clock_pkg;

    localparam int HOUR_HIGH_W = 2;
    localparam int HOUR_LOW_W  = 4;
    localparam int MIN_HIGH_W  = 3;
    localparam int MIN_LOW_W   = 4;
    localparam int SEC_HIGH_W  = 3;
    localparam int SEC_LOW_W   = 4;

    localparam int MAX_HOUR = 23;
    localparam int MAX_MIN  = 59;
    localparam int MAX_SEC  = 59;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RING = 1'b1
    } alarm_state_t;

    // Alarm time is held in BCD so matching is a plain compare against the digit registers.
    typedef struct packed {
        logic       en;
        logic [5:0] hour_bcd;
        logic [6:0] min_bcd;
    } alarm_cfg_t;

    function automatic logic [5:0] hour_to_bcd(input logic [4:0] h);
        return {2'(h / 5'd10), 4'(h % 5'd10)};
    endfunction

    function automatic logic [6:0] min_to_bcd(input logic [5:0] m);
        return {3'(m / 6'd10), 4'(m % 6'd10)};
    endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// rtl/bcd_time_counter.sv - 1 s prescaler and 24 h BCD time-of-day counter with range-checked load
// Ports: clk/rst_n (async active-low); ena gates the prescaler; set_valid + set_hour/min/sec load
// the time; six BCD digit outputs; set_bad flags a rejected load (combinational); sec_tick is the
// accepted one-second advance (combinational); updated is high in the cycle a new time is shown.
module bcd_time_counter
    import clock_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic                   set_valid,
    input  logic [4:0]             set_hour,
    input  logic [5:0]             set_min,
    input  logic [5:0]             set_sec,
    output logic [HOUR_HIGH_W-1:0] hour_high,
    output logic [HOUR_LOW_W-1:0]  hour_low,
    output logic [MIN_HIGH_W-1:0]  minute_high,
    output logic [MIN_LOW_W-1:0]   minute_low,
    output logic [SEC_HIGH_W-1:0]  second_high,
    output logic [SEC_LOW_W-1:0]   second_low,
    output logic                   set_bad,
    output logic                   sec_tick,
    output logic                   updated
);

    localparam int                 PRESC_W    = $clog2(CLK_HZ);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);

    logic [PRESC_W-1:0] presc;
    logic               wrap;
    logic               set_ok;
    logic [5:0]         hour_bcd;
    logic [6:0]         min_bcd;
    logic [6:0]         sec_bcd;

    assign wrap     = ena && (presc == PRESC_LAST);
    assign set_ok   = set_valid && (set_hour <= 5'(MAX_HOUR)) && (set_min <= 6'(MAX_MIN))
                      && (set_sec <= 6'(MAX_SEC));
    assign set_bad  = set_valid && !set_ok;
    // A load in the same cycle as the wrap swallows that second.
    assign sec_tick = wrap && !set_ok;

    assign hour_bcd = hour_to_bcd(set_hour);
    assign min_bcd  = min_to_bcd(set_min);
    assign sec_bcd  = min_to_bcd(set_sec);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc       <= '0;
            hour_high   <= '0;
            hour_low    <= '0;
            minute_high <= '0;
            minute_low  <= '0;
            second_high <= '0;
            second_low  <= '0;
            updated     <= 1'b0;
        end else begin
            updated <= set_ok || wrap;
            if (set_ok) begin
                presc                     <= '0;
                {hour_high, hour_low}     <= hour_bcd;
                {minute_high, minute_low} <= min_bcd;
                {second_high, second_low} <= sec_bcd;
            end else begin
                if (ena) begin
                    presc <= wrap ? '0 : presc + 1'b1;
                end
                if (wrap) begin
                    if (second_low != 4'd9) begin
                        second_low <= second_low + 4'd1;
                    end else begin
                        second_low <= '0;
                        if (second_high != 3'd5) begin
                            second_high <= second_high + 3'd1;
                        end else begin
                            second_high <= '0;
                            if (minute_low != 4'd9) begin
                                minute_low <= minute_low + 4'd1;
                            end else begin
                                minute_low <= '0;
                                if (minute_high != 3'd5) begin
                                    minute_high <= minute_high + 3'd1;
                                end else begin
                                    minute_high <= '0;
                                    if (hour_high == 2'd2 && hour_low == 4'd3) begin
                                        hour_high <= '0;
                                        hour_low  <= '0;
                                    end else if (hour_low == 4'd9) begin
                                        hour_low  <= '0;
                                        hour_high <= hour_high + 2'd1;
                                    end else begin
                                        hour_low <= hour_low + 4'd1;
                                    end
                                end
                            end
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/multi_alarm_clock.sv
// rtl/multi_alarm_clock.sv - 24 h BCD clock with N alarm channels, ring timer and blinking indicator
// Ports: CLK_100M/rst (async active-low); ena, set_valid, set_hour/min/sec drive the time counter;
// alm_we, alm_idx, alm_hour/min, alm_en program a channel; dismiss stops ringing; outputs are the
// six BCD digits, set_err (one-cycle reject pulse), alarm_hit, ringing and blink.
module multi_alarm_clock
    import clock_pkg::*;
#(
    parameter  int CLK_HZ     = 100_000_000,
    parameter  int N_ALARM    = 4,
    parameter  int RING_SECS  = 60,
    parameter  int BLINK_HALF = 25_000_000,
    // One spare code beyond the channel count so out-of-range indices can be presented and rejected.
    localparam int IDX_W      = $clog2(N_ALARM + 1)
) (
    input  logic                   CLK_100M,
    input  logic                   rst,
    input  logic                   ena,
    input  logic                   set_valid,
    input  logic [4:0]             set_hour,
    input  logic [5:0]             set_min,
    input  logic [5:0]             set_sec,
    input  logic                   alm_we,
    input  logic [IDX_W-1:0]       alm_idx,
    input  logic [4:0]             alm_hour,
    input  logic [5:0]             alm_min,
    input  logic                   alm_en,
    input  logic                   dismiss,
    output logic [HOUR_HIGH_W-1:0] hour_high,
    output logic [HOUR_LOW_W-1:0]  hour_low,
    output logic [MIN_HIGH_W-1:0]  minute_high,
    output logic [MIN_LOW_W-1:0]   minute_low,
    output logic [SEC_HIGH_W-1:0]  second_high,
    output logic [SEC_LOW_W-1:0]   second_low,
    output logic                   set_err,
    output logic [N_ALARM-1:0]     alarm_hit,
    output logic                   ringing,
    output logic                   blink
);

    localparam logic [7:0]         RING_LAST  = 8'(RING_SECS - 1);
    localparam int                 BLINK_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

    logic               updated;
    logic               sec_tick;
    logic               set_bad;
    logic               alm_ok;
    logic               alm_bad;
    logic [5:0]         alm_hour_bcd;
    logic [6:0]         alm_min_bcd;
    alarm_cfg_t         cfg [N_ALARM];
    logic [N_ALARM-1:0] match;
    alarm_state_t       state;
    logic [7:0]         ring_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic               ring_exit;

    bcd_time_counter #(.CLK_HZ(CLK_HZ)) u_time (
        .clk         (CLK_100M),
        .rst_n       (rst),
        .ena         (ena),
        .set_valid   (set_valid),
        .set_hour    (set_hour),
        .set_min     (set_min),
        .set_sec     (set_sec),
        .hour_high   (hour_high),
        .hour_low    (hour_low),
        .minute_high (minute_high),
        .minute_low  (minute_low),
        .second_high (second_high),
        .second_low  (second_low),
        .set_bad     (set_bad),
        .sec_tick    (sec_tick),
        .updated     (updated)
    );

    assign alm_ok = alm_we && (alm_idx < IDX_W'(N_ALARM)) && (alm_hour <= 5'(MAX_HOUR))
                    && (alm_min <= 6'(MAX_MIN));
    assign alm_bad      = alm_we && !alm_ok;
    assign alm_hour_bcd = hour_to_bcd(alm_hour);
    assign alm_min_bcd  = min_to_bcd(alm_min);

    always_ff @(posedge CLK_100M or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_ALARM; i++) begin
                cfg[i] <= '0;
            end
            set_err <= 1'b0;
        end else begin
            for (int i = 0; i < N_ALARM; i++) begin
                if (alm_ok && alm_idx == IDX_W'(i)) begin
                    cfg[i] <= {alm_en, alm_hour_bcd, alm_min_bcd};
                end
            end
            // Both strobes may be rejected together; still a single pulse.
            set_err <= set_bad || alm_bad;
        end
    end

    // Only evaluated in the cycle right after the time changed, so a held time or the
    // reset-release value never re-fires an alarm.
    always_comb begin
        match = '0;
        for (int i = 0; i < N_ALARM; i++) begin
            match[i] = updated && cfg[i].en
                       && (cfg[i].hour_bcd == {hour_high, hour_low})
                       && (cfg[i].min_bcd == {minute_high, minute_low})
                       && (second_high == 3'd0) && (second_low == 4'd0);
        end
    end

    // A fresh match always beats dismiss or timeout.
    assign ring_exit = (state == RING) && !(|match)
                       && (dismiss || (sec_tick && ring_cnt == RING_LAST));

    always_ff @(posedge CLK_100M or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            alarm_hit <= '0;
            ring_cnt  <= '0;
            blink     <= 1'b0;
            blink_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|match) begin
                        state     <= RING;
                        alarm_hit <= match;
                        ring_cnt  <= '0;
                        blink     <= 1'b1;
                        blink_cnt <= '0;
                    end
                end
                default: begin
                    if (|match) begin
                        alarm_hit <= alarm_hit | match;
                        ring_cnt  <= '0;
                    end else if (ring_exit) begin
                        state     <= IDLE;
                        alarm_hit <= '0;
                    end else if (sec_tick) begin
                        ring_cnt <= ring_cnt + 8'd1;
                    end
                    if (ring_exit) begin
                        blink     <= 1'b0;
                        blink_cnt <= '0;
                    end else if (blink_cnt == BLINK_LAST) begin
                        blink     <= ~blink;
                        blink_cnt <= '0;
                    end else begin
                        blink_cnt <= blink_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign ringing = (state == RING);

endmodule

// File: tb/tb_multi_alarm_clock.sv
// tb/tb_multi_alarm_clock.sv - scoreboard bench with a seconds-based reference model
module tb_multi_alarm_clock;

    localparam int CLK_HZ     = 10;
    localparam int N_ALARM    = 4;
    localparam int RING_SECS  = 3;
    localparam int BLINK_HALF = 2;
    localparam int IDX_W      = $clog2(N_ALARM + 1);

    logic               clk = 1'b0;
    logic               rst;
    logic               ena;
    logic               set_valid;
    logic [4:0]         set_hour;
    logic [5:0]         set_min;
    logic [5:0]         set_sec;
    logic               alm_we;
    logic [IDX_W-1:0]   alm_idx;
    logic [4:0]         alm_hour;
    logic [5:0]         alm_min;
    logic               alm_en;
    logic               dismiss;
    logic [1:0]         hour_high;
    logic [3:0]         hour_low;
    logic [2:0]         minute_high;
    logic [3:0]         minute_low;
    logic [2:0]         second_high;
    logic [3:0]         second_low;
    logic               set_err;
    logic [N_ALARM-1:0] alarm_hit;
    logic               ringing;
    logic               blink;

    multi_alarm_clock #(
        .CLK_HZ     (CLK_HZ),
        .N_ALARM    (N_ALARM),
        .RING_SECS  (RING_SECS),
        .BLINK_HALF (BLINK_HALF)
    ) dut (
        .CLK_100M    (clk),
        .rst         (rst),
        .ena         (ena),
        .set_valid   (set_valid),
        .set_hour    (set_hour),
        .set_min     (set_min),
        .set_sec     (set_sec),
        .alm_we      (alm_we),
        .alm_idx     (alm_idx),
        .alm_hour    (alm_hour),
        .alm_min     (alm_min),
        .alm_en      (alm_en),
        .dismiss     (dismiss),
        .hour_high   (hour_high),
        .hour_low    (hour_low),
        .minute_high (minute_high),
        .minute_low  (minute_low),
        .second_high (second_high),
        .second_low  (second_low),
        .set_err     (set_err),
        .alarm_hit   (alarm_hit),
        .ringing     (ringing),
        .blink       (blink)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0]        digits;
        bit                 err;
        logic [N_ALARM-1:0] hit;
        bit                 ring;
        bit                 blk;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: wall time as seconds since midnight, ringing tracked as elapsed
    // ticks and elapsed cycles since the ring began.
    int                 m_presc;
    int                 m_secs;
    bit                 m_upd;
    bit                 m_err;
    bit                 m_ring;
    logic [N_ALARM-1:0] m_hit;
    int                 m_tsince;
    int                 m_rcyc;
    bit                 m_aen [N_ALARM];
    int                 m_ah  [N_ALARM];
    int                 m_am  [N_ALARM];

    function automatic logic [19:0] digits_of(input int s);
        int h, m, x;
        h = s / 3600;
        m = (s / 60) % 60;
        x = s % 60;
        return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(x / 10), 4'(x % 10)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_presc  = 0;
        m_secs   = 0;
        m_upd    = 0;
        m_err    = 0;
        m_ring   = 0;
        m_hit    = '0;
        m_tsince = 0;
        m_rcyc   = 0;
        for (int i = 0; i < N_ALARM; i++) begin
            m_aen[i] = 0;
            m_ah[i]  = 0;
            m_am[i]  = 0;
        end
    endtask

    // Advance the model across one rising edge using the inputs currently driven, then
    // queue what the DUT should present after that edge.
    task automatic model_step();
        bit                 tick, set_ok, alm_ok, tick_ring;
        logic [N_ALARM-1:0] match;
        exp_t               e;
        int                 idx;
        idx    = int'(alm_idx);
        tick   = ena && (m_presc == CLK_HZ - 1);
        set_ok = set_valid && set_hour <= 23 && set_min <= 59 && set_sec <= 59;
        alm_ok = alm_we && idx < N_ALARM && alm_hour <= 23 && alm_min <= 59;
        match  = '0;
        if (m_upd && (m_secs % 60) == 0) begin
            for (int c = 0; c < N_ALARM; c++) begin
                if (m_aen[c] && m_ah[c] == m_secs / 3600 && m_am[c] == (m_secs / 60) % 60)
                    match[c] = 1'b1;
            end
        end
        tick_ring = tick && !set_ok;
        if (!m_ring) begin
            if (match != '0) begin
                m_ring   = 1;
                m_hit    = match;
                m_tsince = 0;
                m_rcyc   = 0;
            end
        end else if (match != '0) begin
            m_hit    = m_hit | match;
            m_tsince = 0;
            m_rcyc++;
        end else if (dismiss || (tick_ring && m_tsince + 1 == RING_SECS)) begin
            m_ring = 0;
            m_hit  = '0;
        end else begin
            if (tick_ring) m_tsince++;
            m_rcyc++;
        end
        if (alm_ok) begin
            m_aen[idx] = alm_en;
            m_ah[idx]  = int'(alm_hour);
            m_am[idx]  = int'(alm_min);
        end
        if (set_ok) begin
            m_secs  = int'(set_hour) * 3600 + int'(set_min) * 60 + int'(set_sec);
            m_presc = 0;
        end else begin
            if (tick) m_secs = (m_secs + 1) % 86400;
            if (ena) m_presc = (m_presc + 1) % CLK_HZ;
        end
        m_upd    = set_ok || tick;
        m_err    = (set_valid && !set_ok) || (alm_we && !alm_ok);
        e.digits = digits_of(m_secs);
        e.err    = m_err;
        e.hit    = m_hit;
        e.ring   = m_ring;
        e.blk    = m_ring && ((m_rcyc / BLINK_HALF) % 2 == 0);
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("time", 32'({hour_high, hour_low, minute_high, minute_low, second_high, second_low}),
                    32'(e.digits));
                chk("set_err", 32'(set_err), 32'(e.err));
                chk("alarm_hit", 32'(alarm_hit), 32'(e.hit));
                chk("ringing", 32'(ringing), 32'(e.ring));
                chk("blink", 32'(blink), 32'(e.blk));
            end
        end
    end

    task automatic step();
        model_step();
        @(negedge clk);
        set_valid = 1'b0;
        alm_we    = 1'b0;
        dismiss   = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_set(input int h, input int m, input int s);
        set_valid = 1'b1;
        set_hour  = 5'(h);
        set_min   = 6'(m);
        set_sec   = 6'(s);
        step();
    endtask

    task automatic do_alarm(input int idx, input int h, input int m, input bit en);
        alm_we   = 1'b1;
        alm_idx  = IDX_W'(idx);
        alm_hour = 5'(h);
        alm_min  = 6'(m);
        alm_en   = en;
        step();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_time"}, 32'({hour_high, hour_low, minute_high, minute_low, second_high, second_low}), 32'd0);
        chk({tag, "_set_err"}, 32'(set_err), 32'd0);
        chk({tag, "_alarm_hit"}, 32'(alarm_hit), 32'd0);
        chk({tag, "_ringing"}, 32'(ringing), 32'd0);
        chk({tag, "_blink"}, 32'(blink), 32'd0);
    endtask

    function automatic int rand_hour();
        return ($urandom_range(0, 4) == 0) ? $urandom_range(24, 31) : $urandom_range(6, 8);
    endfunction

    function automatic int rand_min();
        return ($urandom_range(0, 9) == 0) ? $urandom_range(60, 63) : $urandom_range(0, 2);
    endfunction

    initial begin : stimulus
        int r;
        rst       = 1'b0;
        ena       = 1'b0;
        set_valid = 1'b0;
        set_hour  = '0;
        set_min   = '0;
        set_sec   = '0;
        alm_we    = 1'b0;
        alm_idx   = '0;
        alm_hour  = '0;
        alm_min   = '0;
        alm_en    = 1'b0;
        dismiss   = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        ena = 1'b1;

        // Midnight rollover.
        do_set(23, 59, 58);
        run(25);

        // Rejected writes, alone and together.
        do_set(25, 0, 0);
        run(2);
        do_alarm(5, 7, 30, 1);
        run(2);
        set_valid = 1'b1; set_hour = 5'd24; set_min = 6'd0; set_sec = 6'd0;
        alm_we = 1'b1; alm_idx = 3'd1; alm_hour = 5'd30; alm_min = 6'd0; alm_en = 1'b1;
        step();
        run(2);

        // Single channel rings for RING_SECS ticks then times out.
        do_alarm(2, 7, 30, 1);
        do_set(7, 29, 59);
        run(45);

        // Two channels at once, dismissed.
        do_alarm(0, 8, 0, 1);
        do_alarm(3, 8, 0, 1);
        do_set(8, 0, 0);
        run(5);
        dismiss = 1'b1;
        step();
        run(4);

        // Re-match coinciding with dismiss keeps ringing; disabling a channel keeps its hit bit.
        do_alarm(1, 9, 0, 1);
        do_set(9, 0, 0);
        run(3);
        do_set(9, 0, 0);
        dismiss = 1'b1;
        step();
        run(3);
        do_alarm(1, 9, 0, 0);
        run(3);
        dismiss = 1'b1;
        step();
        run(2);

        // Frozen time pauses the ring timer.
        do_set(7, 30, 0);
        ena = 1'b0;
        run(40);
        ena = 1'b1;
        run(40);

        // Load on the same edge as a tick.
        for (int i = 0; i < CLK_HZ; i++) begin
            if (m_presc == CLK_HZ - 1) break;
            step();
        end
        do_set(12, 34, 56);
        run(12);

        // Asynchronous reset in the middle of ringing.
        do_set(8, 0, 0);
        run(4);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("midring_reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        run(15);

        // Randomized traffic.
        for (int i = 0; i < 900; i++) begin
            ena = ($urandom_range(0, 9) != 0);
            r   = $urandom_range(0, 99);
            if (r < 5) begin
                set_valid = 1'b1;
                set_hour  = 5'(rand_hour());
                set_min   = 6'(rand_min());
                r         = $urandom_range(0, 3);
                set_sec   = (r == 0) ? 6'd0 : (r == 1) ? 6'($urandom_range(0, 63)) : 6'd59;
            end
            r = $urandom_range(0, 99);
            if (r < 4) begin
                alm_we   = 1'b1;
                alm_idx  = IDX_W'($urandom_range(0, 5));
                alm_hour = 5'(rand_hour());
                alm_min  = 6'(rand_min());
                alm_en   = ($urandom_range(0, 3) != 0);
            end
            dismiss = ($urandom_range(0, 99) < 3);
            step();
        end

        for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
        chk("drain", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
